// File: rtl/uart_pkg.sv
// Shared UART definitions for the TX block and the future RX block.
//   - Parity mode encodings used by the PARITY parameter.
//   - Frame FSM state encoding.
//   - frame_clks(): clock cycles taken by one complete frame.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  function automatic int frame_clks(input int clks_per_bit, input int data_bits,
                                    input int parity, input int stop_bits);
    return clks_per_bit * (1 + data_bits + ((parity != PAR_NONE) ? 1 : 0) + stop_bits);
  endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Generic synchronous FIFO, first-word-fall-through read port.
// Ports:
//   clk, tx_rst_n      clock, async active-low reset (empties the FIFO)
//   push, push_data    write strobe and data (ignored when full)
//   pop                read strobe; pop_data shows the head entry (ignored when empty)
//   full, empty, level occupancy flags and count, all taken from registers
module uart_sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int LW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             tx_rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty,
  output logic [LW-1:0]    level
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok;
  logic             pop_ok;

  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;

  // NOTE: storage is deliberately left out of reset; the pointers and level
  // define which entries are valid, so clearing the array buys nothing.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  // DEPTH is a power of two, so the pointers wrap naturally.
  assign pop_data = mem_q[rd_ptr_q];
  assign full     = (level_q == LW'(DEPTH));
  assign empty    = (level_q == '0);
  assign level    = level_q;

endmodule

// File: rtl/uart_tx_fifo_param.sv
// Buffered UART transmitter with compile-time frame format.
// Words enter a FIFO through start/tx_data_in and are sent LSB-first as
// start bit, DATA_BITS data bits, optional parity bit, STOP_BITS stop bits.
// Consecutive frames are sent back-to-back with no idle gap.
// Ports:
//   clk, tx_rst_n   clock, async active-low reset
//   start           write strobe for tx_data_in (accepted when FIFO not full)
//   tx_ready        FIFO not full
//   tx_overflow     one-cycle pulse after a start was rejected
//   fifo_level      queued words, excluding the frame in flight
//   tx_serial_out   serial line, idle high
//   tx_busy         a frame is on the line
//   tx_done         high during the last clock of the last stop bit
module uart_tx_fifo_param
  import uart_pkg::*;
#(
  parameter  int CLKS_PER_BIT = 5208,
  parameter  int DATA_BITS    = 8,
  parameter  int PARITY       = 0,
  parameter  int STOP_BITS    = 1,
  parameter  int FIFO_DEPTH   = 4,
  localparam int LVL_W        = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                 clk,
  input  logic                 tx_rst_n,
  input  logic                 start,
  input  logic [DATA_BITS-1:0] tx_data_in,
  output logic                 tx_ready,
  output logic                 tx_overflow,
  output logic [LVL_W-1:0]     fifo_level,
  output logic                 tx_serial_out,
  output logic                 tx_busy,
  output logic                 tx_done
);

  localparam int                BAUD_W    = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [3:0]        DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [3:0]        STOP_LAST = 4'(STOP_BITS - 1);

  logic [2:0]           state_q, state_d;
  logic [BAUD_W-1:0]    baud_q, baud_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 line_q, line_d;
  logic                 busy_q, done_q, ovf_q;
  logic                 done_d;
  logic                 baud_wrap;

  logic                 push, pop;
  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full, fifo_empty;

  // A start against a full FIFO is rejected even if a pop frees a slot at
  // the same edge: acceptance depends only on the pre-edge level.
  assign push = start && !fifo_full;

  uart_sync_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .tx_rst_n  (tx_rst_n),
    .push      (push),
    .push_data (tx_data_in),
    .pop       (pop),
    .pop_data  (fifo_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (fifo_level)
  );

  assign baud_wrap = (baud_q == BAUD_LAST);

  // NOTE: every signal assigned here gets a default first, so no path
  // through the case leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    pop     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bit_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = ST_START;
        end
      end
      ST_START: begin
        if (baud_wrap) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (baud_wrap) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      ST_PARITY: begin
        if (baud_wrap) state_d = ST_STOP;
      end
      ST_STOP: begin
        if (baud_wrap) begin
          if (bit_q == STOP_LAST) begin
            bit_d = '0;
            if (!fifo_empty) begin
              pop     = 1'b1;
              state_d = ST_START;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // The baud counter only runs while a frame is on the line, so every
    // frame starts with a full-length start bit.
    if (state_q == ST_IDLE) baud_d = '0;
    else                    baud_d = baud_wrap ? '0 : baud_q + BAUD_W'(1);

    // Word and parity are captured at pop; later pushes cannot disturb them.
    if (pop) begin
      shift_d = fifo_data;
      par_d   = (PARITY == PAR_ODD) ? ~^fifo_data : ^fifo_data;
    end
  end

  // Outputs are computed from next-state values and registered, which keeps
  // them glitch-free while still changing on the same edge as the state.
  always_comb begin
    case (state_d)
      ST_START:  line_d = 1'b0;
      ST_DATA:   line_d = shift_d[0];
      ST_PARITY: line_d = par_d;
      default:   line_d = 1'b1;
    endcase
  end

  assign done_d = (state_d == ST_STOP) && (baud_d == BAUD_LAST) && (bit_d == STOP_LAST);

  always_ff @(posedge clk or negedge tx_rst_n) begin
    if (!tx_rst_n) begin
      state_q <= ST_IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      par_q   <= 1'b0;
      line_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
      par_q   <= par_d;
      line_q  <= line_d;
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= done_d;
      ovf_q   <= start && fifo_full;
    end
  end

  assign tx_ready      = !fifo_full;
  assign tx_overflow   = ovf_q;
  assign tx_serial_out = line_q;
  assign tx_busy       = busy_q;
  assign tx_done       = done_q;

endmodule

// File: tb/tb_uart_tx_fifo_param.sv
// Self-checking bench for uart_tx_fifo_param.
// Three builds share clock and reset:
//   dut_m : CLKS_PER_BIT=4, 8 data bits, even parity, 1 stop, depth 4
//   dut_p : as dut_m but odd parity
//   dut_a : 5 data bits, no parity, 2 stop bits
// dut_m is also compared every cycle against a frame-level reference model.
module tb_uart_tx_fifo_param;

  localparam int CPB     = 4;
  localparam int DEPTH   = 4;
  localparam int FRAME_M = CPB * 11;
  localparam int FRAME_A = CPB * 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Main build
  logic       start_m = 1'b0;
  logic [7:0] data_m  = '0;
  logic       ready_m, ovf_m, line_m, busy_m, done_m;
  logic [2:0] level_m;

  uart_tx_fifo_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut_m (
    .clk(clk), .tx_rst_n(rst_n), .start(start_m), .tx_data_in(data_m),
    .tx_ready(ready_m), .tx_overflow(ovf_m), .fifo_level(level_m),
    .tx_serial_out(line_m), .tx_busy(busy_m), .tx_done(done_m)
  );

  // Odd-parity build
  logic       start_p = 1'b0;
  logic [7:0] data_p  = '0;
  logic       ready_p, ovf_p, line_p, busy_p, done_p;
  logic [2:0] level_p;

  uart_tx_fifo_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1), .FIFO_DEPTH(DEPTH)
  ) dut_p (
    .clk(clk), .tx_rst_n(rst_n), .start(start_p), .tx_data_in(data_p),
    .tx_ready(ready_p), .tx_overflow(ovf_p), .fifo_level(level_p),
    .tx_serial_out(line_p), .tx_busy(busy_p), .tx_done(done_p)
  );

  // Alternate build
  logic       start_a = 1'b0;
  logic [4:0] data_a  = '0;
  logic       ready_a, ovf_a, line_a, busy_a, done_a;
  logic [2:0] level_a;

  uart_tx_fifo_param #(
    .CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(0), .STOP_BITS(2), .FIFO_DEPTH(DEPTH)
  ) dut_a (
    .clk(clk), .tx_rst_n(rst_n), .start(start_a), .tx_data_in(data_a),
    .tx_ready(ready_a), .tx_overflow(ovf_a), .fifo_level(level_a),
    .tx_serial_out(line_a), .tx_busy(busy_a), .tx_done(done_a)
  );

  // ---------------- reference model for dut_m ----------------
  // Queue of accepted words plus the bit sequence of the frame on the line;
  // m_t counts clocks into that frame.
  int unsigned m_q[$];
  bit          m_active = 1'b0;
  int          m_t      = 0;
  logic [10:0] m_bits   = '1;
  bit          m_ovf    = 1'b0;

  function automatic logic [10:0] frame_of(input logic [7:0] d);
    logic [10:0] b;
    b[0] = 1'b0;
    for (int i = 0; i < 8; i++) b[1 + i] = d[i];
    b[9]  = ^d;
    b[10] = 1'b1;
    return b;
  endfunction

  initial begin
    int pre;
    bit accept;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_q.delete();
        m_active = 1'b0;
        m_t      = 0;
        m_ovf    = 1'b0;
      end else begin
        pre    = m_q.size();
        accept = start_m && (pre < DEPTH);
        if (m_active && m_t < FRAME_M - 1) begin
          m_t++;
        end else if (pre > 0) begin
          m_bits   = frame_of(8'(m_q.pop_front()));
          m_t      = 0;
          m_active = 1'b1;
        end else begin
          m_active = 1'b0;
          m_t      = 0;
        end
        if (accept) m_q.push_back(int'(data_m));
        m_ovf = start_m && !accept;
      end
    end
  end

  // Cycle-by-cycle comparison of every dut_m output with the model.
  initial begin
    logic [7:0] act, exp;
    forever begin
      @(negedge clk);
      act = {line_m, busy_m, done_m, ready_m, ovf_m, level_m};
      exp = {(m_active ? m_bits[m_t / CPB] : 1'b1), m_active,
             (m_active && m_t == FRAME_M - 1), (m_q.size() < DEPTH), m_ovf,
             3'(m_q.size())};
      check("model{line,busy,done,ready,ovf,level}", 32'(act), 32'(exp));
    end
  end

  // ---------------- directed vectors ----------------
  typedef struct {
    logic [7:0]  data;
    logic [10:0] bits;   // bits[k] = expected line level during bit k
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic        cap[64];
    logic [3:0]  win;
    logic [10:0] odd_bits;
    logic [7:0]  alt_bits;
    int          done_cnt, done_at, ovf_cnt, busy_gap, zero_cnt;

    vecs[0] = '{8'h55, 11'b1_0_01010101_0};
    vecs[1] = '{8'h37, 11'b1_1_00110111_0};
    vecs[2] = '{8'h00, 11'b1_0_00000000_0};
    vecs[3] = '{8'hFF, 11'b1_0_11111111_0};
    vecs[4] = '{8'h80, 11'b1_1_10000000_0};
    vecs[5] = '{8'hA5, 11'b1_0_10100101_0};
    odd_bits = 11'b1_0_00110111_0;
    alt_bits = 8'b11_10101_0;

    // Reset
    rst_n = 1'b0;
    repeat (5) @(negedge clk);
    check("rst_line",  32'(line_m),  32'd1);
    check("rst_ready", 32'(ready_m), 32'd1);
    check("rst_level", 32'(level_m), 32'd0);
    check("rst_busy",  32'(busy_m),  32'd0);
    check("rst_done",  32'(done_m),  32'd0);
    check("rst_ovf",   32'(ovf_m),   32'd0);
    check("rst_line_alt", 32'(line_a), 32'd1);
    check("rst_line_odd", 32'(line_p), 32'd1);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Single frames from idle, table driven
    for (int i = 0; i < 6; i++) begin
      start_m = 1'b1;
      data_m  = vecs[i].data;
      @(negedge clk);
      start_m = 1'b0;
      check($sformatf("v%0d_line_before_fall", i), 32'(line_m), 32'd1);
      done_cnt = 0;
      done_at  = -1;
      for (int c = 0; c < FRAME_M; c++) begin
        @(negedge clk);
        cap[c] = line_m;
        if (done_m) begin
          done_cnt++;
          done_at = c;
        end
      end
      for (int k = 0; k < 11; k++) begin
        win = {cap[4*k+3], cap[4*k+2], cap[4*k+1], cap[4*k]};
        check($sformatf("v%0d_bit%0d", i, k), 32'(win), 32'({4{vecs[i].bits[k]}}));
      end
      check($sformatf("v%0d_done_count", i), 32'(done_cnt), 32'd1);
      check($sformatf("v%0d_done_cycle", i), 32'(done_at), 32'(FRAME_M - 1));
      @(negedge clk);
      check($sformatf("v%0d_idle_after", i), 32'(busy_m), 32'd0);
    end

    // Odd parity: 0x37 has five ones, so the parity bit is 0
    start_p = 1'b1;
    data_p  = 8'h37;
    @(negedge clk);
    start_p = 1'b0;
    for (int c = 0; c < FRAME_M; c++) begin
      @(negedge clk);
      cap[c] = line_p;
    end
    for (int k = 0; k < 11; k++) begin
      win = {cap[4*k+3], cap[4*k+2], cap[4*k+1], cap[4*k]};
      check($sformatf("odd_bit%0d", k), 32'(win), 32'({4{odd_bits[k]}}));
    end
    repeat (2) @(negedge clk);

    // Alternate build: 0x15, 5N2, 32 clocks
    start_a = 1'b1;
    data_a  = 5'h15;
    @(negedge clk);
    start_a = 1'b0;
    check("alt_line_before_fall", 32'(line_a), 32'd1);
    done_cnt = 0;
    done_at  = -1;
    for (int c = 0; c < FRAME_A; c++) begin
      @(negedge clk);
      cap[c] = line_a;
      if (done_a) begin
        done_cnt++;
        done_at = c;
      end
    end
    for (int k = 0; k < 8; k++) begin
      win = {cap[4*k+3], cap[4*k+2], cap[4*k+1], cap[4*k]};
      check($sformatf("alt_bit%0d", k), 32'(win), 32'({4{alt_bits[k]}}));
    end
    check("alt_done_count", 32'(done_cnt), 32'd1);
    check("alt_done_cycle", 32'(done_at), 32'(FRAME_A - 1));
    @(negedge clk);
    check("alt_idle_after", 32'(busy_a), 32'd0);

    // Burst of six starts: five accepted, the sixth overflows
    ovf_cnt  = 0;
    done_cnt = 0;
    busy_gap = 0;
    start_m  = 1'b1;
    data_m   = 8'h01;
    for (int s = 0; s <= 5 * FRAME_M + 5; s++) begin
      @(negedge clk);
      if (s < 5) begin
        start_m = 1'b1;
        data_m  = 8'(s + 2);
      end else begin
        start_m = 1'b0;
      end
      if (ovf_m) ovf_cnt++;
      if (done_m) done_cnt++;
      if (s >= 1 && s <= 5 * FRAME_M && !busy_m) busy_gap++;
      if (s == 4) begin
        check("burst_level_full", 32'(level_m), 32'd4);
        check("burst_ready_low",  32'(ready_m), 32'd0);
      end
      if (s == 5) check("burst_ovf_pulse", 32'(ovf_m), 32'd1);
      if (s == 5 * FRAME_M + 1) check("burst_idle_after", 32'(busy_m), 32'd0);
    end
    check("burst_ovf_count",  32'(ovf_cnt),  32'd1);
    check("burst_done_count", 32'(done_cnt), 32'd5);
    check("burst_busy_gaps",  32'(busy_gap), 32'd0);

    // Reset during data bit 3, with a second word queued
    start_m = 1'b1;
    data_m  = 8'hA5;
    @(negedge clk);
    data_m  = 8'h3C;
    @(negedge clk);
    start_m = 1'b0;
    repeat (17) @(negedge clk);
    check("mr_in_frame_busy", 32'(busy_m),  32'd1);
    check("mr_in_frame_lvl",  32'(level_m), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_line",  32'(line_m),  32'd1);
    check("mr_busy",  32'(busy_m),  32'd0);
    check("mr_level", 32'(level_m), 32'd0);
    check("mr_done",  32'(done_m),  32'd0);
    done_cnt = 0;
    zero_cnt = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_m) done_cnt++;
      if (!line_m) zero_cnt++;
    end
    rst_n = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (done_m) done_cnt++;
      if (!line_m) zero_cnt++;
    end
    check("mr_no_done",   32'(done_cnt), 32'd0);
    check("mr_line_idle", 32'(zero_cnt), 32'd0);

    // Random traffic against the model
    for (int n = 0; n < 1500; n++) begin
      start_m = ($urandom_range(0, 3) == 0);
      data_m  = 8'($urandom);
      @(negedge clk);
    end
    start_m = 1'b0;
    repeat (6 * FRAME_M) @(negedge clk);
    check("drain_busy",  32'(busy_m),  32'd0);
    check("drain_level", 32'(level_m), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_param.md
# uart_tx_fifo_param

Parametrised, buffered UART transmitter, the next generation of the fixed 8N1 `UART_Tx`. It accepts words through a ready/strobe interface into an internal FIFO. It serialises them LSB-first with a compile-time frame format: 5–9 data bits, none/even/odd parity, and 1 or 2 stop bits. Frames go out back-to-back with no idle gap. It sits between the register/bus side of the UART IP and the TX pad.

## Interface
- CLKS_PER_BIT, 5208: clocks per serial bit (50 MHz / 9600). Minimum 2.
- DATA_BITS, 8: data bits per frame, 5..9.
- PARITY, 0: 0 none, 1 even, 2 odd.
- STOP_BITS, 1: 1 or 2.
- FIFO_DEPTH, 4: FIFO entries, power of two, at least 2.

Ports:
- clk  in  1  single system clock, rising edge.
- tx_rst_n  in  1  reset, asynchronous assert, active-low. Already decided.
- start  in  1  write strobe; pushes tx_data_in when sampled high and the FIFO is not full.
- tx_data_in  in  DATA_BITS  word to send.
- tx_ready  out  1  FIFO not full (level < FIFO_DEPTH).
- tx_overflow  out  1  one-cycle pulse when a start is rejected.
- fifo_level  out  $clog2(FIFO_DEPTH+1)  words queued, excluding the word in flight.
- tx_serial_out  out  1  serial line, idle high.
- tx_busy  out  1  high while a frame is on the line.
- tx_done  out  1  one-cycle pulse at the end of each frame.

## Operation
- Reset values: tx_serial_out=1, tx_ready=1, tx_busy=0, tx_done=0, tx_overflow=0, fifo_level=0. FSM is in IDLE.
- Push: start=1 at an edge with level<FIFO_DEPTH stores the word and increments the level.
- Full FIFO: start=1 at an edge with level==FIFO_DEPTH drops the word and pulses tx_overflow. This holds even if a pop happens at the same edge.
- Pop: occurs when the FSM leaves IDLE or STOP toward START with the FIFO non-empty. Push and pop at the same edge leave the level unchanged.
- FSM states: IDLE → START → DATA → [PARITY] → STOP → IDLE or START.
  - IDLE: line 1. With the FIFO non-empty, pop, load the shift register, and go to START.
  - START: line 0 for CLKS_PER_BIT cycles.
  - DATA: DATA_BITS bits, LSB first, each CLKS_PER_BIT cycles. Bit index counts 0..DATA_BITS-1.
  - PARITY: present only when PARITY≠0. Even parity sends the XOR of the data bits; odd parity sends its inverse.
  - STOP: line 1 for STOP_BITS×CLKS_PER_BIT cycles. At the last cycle, pulse tx_done. Then go to START if the FIFO is non-empty (pop), otherwise IDLE.
- Baud counter: 0..CLKS_PER_BIT-1 and wraps. State and bit advance only on wrap.
- The data word and parity are latched at pop. Pushes during a frame never affect the frame in flight.
- tx_busy is high in START, DATA, PARITY and STOP. It stays high across back-to-back frames.
- Reset mid-frame: the line goes to 1 immediately (asynchronous). The FIFO empties, the in-flight frame is abandoned, and no tx_done is issued.

## Timing
- Frame length is exactly CLKS_PER_BIT × (1 + DATA_BITS + (PARITY≠0) + STOP_BITS) cycles.
- Idle-to-line latency: start sampled at edge N with FSM idle and FIFO empty.
  - Push at N, pop at N+1.
  - tx_serial_out falls after edge N+1.
- tx_done is high during the final clock of the last stop bit. Next edge: START begins (line falls) or IDLE is entered.
- tx_ready and fifo_level update on the edge after a push or pop.
- tx_overflow is high for the cycle after the rejected edge.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- Shared package uart_pkg holds the parity encodings (PAR_NONE/EVEN/ODD), the FSM state encoding, and a frame-length helper function. The future RX block reuses these.
- Sub-module uart_sync_fifo: a generic synchronous FIFO (WIDTH, DEPTH, push/pop/full/empty/level), clocked by clk and reset by tx_rst_n.
- The top level holds the FSM, baud counter, bit counter, shift register and parity generator.

## Test plan
Default bench: CLKS_PER_BIT=4, DATA_BITS=8, PARITY=1, STOP_BITS=1, FIFO_DEPTH=4.
- Reset: hold tx_rst_n=0 for 5 cycles → line=1, tx_ready=1, fifo_level=0, busy/done/overflow=0.
- Send 0x55 → line 0,1,0,1,0,1,0,1,0,0(parity),1, each bit 4 clocks, 44 clocks total. One tx_done pulse. Line falls one edge after the start edge.
- Send 0x37 → data 1,1,1,0,1,1,0,0, parity 1, stop 1. With PARITY=2, the parity bit is 0.
- Burst: six consecutive start pulses with 0x01..0x06.
  - 0x01..0x05 accepted; 0x06 rejected with one tx_overflow pulse.
  - tx_ready low while level=4.
  - Five frames back-to-back with no idle gap; five tx_done pulses; busy high throughout.
- Reset mid-frame: drop tx_rst_n during data bit 3 → line=1 immediately, busy=0, level=0, no tx_done. After release the line stays idle.
- Alternate build (DATA_BITS=5, PARITY=0, STOP_BITS=2): send 0x15 → line 0,1,0,1,0,1,1,1, 32 clocks total, tx_done in the last clock.
